// File: rtl/adder_share_pkg.sv
// Shared types and default sizing for the adder_share_arb block.
package adder_share_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/adder32.sv
// WIDTH-bit adder with carry out; the single shared datapath of adder_share_arb.
module adder32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arb.sv
// NREQ requesters share one adder through a single-entry result register.
// Define ADDER_SHARE_ARB_RR_EN for round-robin grant; default is fixed priority (lowest index).
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    // Handshake: a transfer happens on any side in a cycle where its valid and
    // ready are both 1; valid never waits on ready, payload is held while stalled.

    state_t           state, state_nxt;
    logic             can_accept;
    logic             any_valid;
    logic [IDW-1:0]   grant_idx;
    logic             transfer;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

`ifdef ADDER_SHARE_ARB_RR_EN
    logic [IDW-1:0] ptr;

    // Search starts at ptr and wraps; the first valid requester found wins.
    always_comb begin
        int j;
        any_valid = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any_valid && req_valid[j]) begin
                any_valid = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end
`else
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end
`endif

    // A full result register may refill only in the cycle it is drained.
    assign can_accept = !rst && ((state == EMPTY) || rsp_ready);
    assign transfer   = can_accept && any_valid;

    always_comb begin
        req_ready = '0;
        if (transfer) req_ready[grant_idx] = 1'b1;
    end

    assign sel_a = req_a[grant_idx*WIDTH +: WIDTH];
    assign sel_b = req_b[grant_idx*WIDTH +: WIDTH];

    adder32 #(.WIDTH(WIDTH)) u_adder (
        .a    (sel_a),
        .b    (sel_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (transfer) state_nxt = FULL;
            FULL:  if (rsp_ready && !transfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
        end else begin
            state <= state_nxt;
            if (transfer) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
                rsp_id   <= grant_idx;
            end
        end
    end

`ifdef ADDER_SHARE_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign rsp_valid = (state == FULL);

endmodule

// File: doc/adder_share_arb.md
ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters sharing one adder (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 32, operand width.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req_valid, input, NREQ: per-requester operand valid.
REQ-006 Port req_ready, output, NREQ: per-requester accept; one-hot or zero.
REQ-007 Port req_a, input, NREQ*WIDTH: operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 Port req_b, input, NREQ*WIDTH: operand B, same packing.
REQ-009 Port rsp_valid, output, 1: result register holds a result.
REQ-010 Port rsp_ready, input, 1: consumer accepts result.
REQ-011 Port rsp_sum, output, WIDTH: A+B modulo 2^WIDTH.
REQ-012 Port rsp_cout, output, 1: carry out of the WIDTH-bit add.
REQ-013 Port rsp_id, output, clog2(NREQ): index of requester that issued the result.

Function
REQ-014 A transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-015 FSM states SHALL be EMPTY (result register empty) and FULL (result register holds unconsumed result).
REQ-016 req_ready SHALL be nonzero only when state is EMPTY, or FULL with rsp_ready=1 (drain and refill same cycle).
REQ-017 When accept is possible, exactly one requester with req_valid=1 SHALL be granted; req_ready SHALL be combinational from req_valid, state, rsp_ready and pointer.
REQ-018 The granted operands SHALL be added by one shared adder; {rsp_cout, rsp_sum} SHALL equal zero-extended A + B, registered with rsp_id one cycle after the transfer.
REQ-019 Latency SHALL be 1 cycle (transfer in cycle N, rsp_valid=1 in N+1); sustained throughput SHALL be 1 result per cycle while rsp_ready=1.
REQ-020 While rsp_valid=1 and rsp_ready=0, rsp_sum, rsp_cout and rsp_id SHALL hold stable and req_ready SHALL be all zero.
REQ-021 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready with no transfer; FULL->FULL on rsp_ready with transfer, or on no rsp_ready.
REQ-022 With no req_valid set, no transfer SHALL occur and req_ready SHALL be zero.
REQ-023 A requester dropping req_valid before a grant SHALL not be penalised; operands SHALL be sampled only on the transfer cycle.
REQ-024 Overflow (e.g. 0xFFFFFFFF + 1) SHALL yield rsp_sum=0, rsp_cout=1; no other flag is produced.

Reset
REQ-025 With rst=1 at a clock edge the block SHALL enter EMPTY; rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, priority pointer=0.
REQ-026 req_ready SHALL be all zero while rst=1; a result pending at reset SHALL be discarded.

Configuration
REQ-027 Macro ADDER_SHARE_ARB_RR_EN SHALL select the grant policy.
REQ-028 With ADDER_SHARE_ARB_RR_EN defined: round-robin; search starts at pointer, pointer SHALL move to (granted index + 1) mod NREQ after each transfer.
REQ-029 Without ADDER_SHARE_ARB_RR_EN: fixed priority, lowest index wins; no pointer register.

Structure
REQ-030 A shared package adder_share_pkg SHALL hold the state enum (EMPTY, FULL) and default WIDTH/NREQ constants.
REQ-031 The adder SHALL be one sub-module adder32 (WIDTH-bit A+B with carry out), instantiated exactly once.
REQ-032 The grant logic SHALL be inline; no second sub-module.

Verification
REQ-033 Reset: rst=1 two cycles, all req_valid=1 -> req_ready=0, rsp_valid=0 throughout, rsp_sum=0.
REQ-034 Single request: req 2 A=8589931, B=10, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=8589941, rsp_cout=0, rsp_id=2.
REQ-035 Overflow: req 0 A=0xFFFFFFFF, B=0x00000001 -> rsp_sum=0, rsp_cout=1, rsp_id=0.
REQ-036 Backpressure: result pending, rsp_ready=0 for 5 cycles, req 1 valid -> outputs stable, req_ready=0; rsp_ready=1 -> req 1 accepted same cycle, its result next cycle.
REQ-037 Contention, RR_EN defined: all 4 valid, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
REQ-038 Contention, RR_EN undefined: requesters 1 and 3 valid for 4 cycles -> rsp_id 1 every cycle, requester 3 never granted.
